// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller state encodings and the divide-by-zero LO constant.
package mips_pkg;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPrep  = 3'd1,
    StRun   = 3'd2,
    StFixup = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned MaxWidth = 64;

  // LO result of any divide by zero; sliced down to the operand width.
  localparam logic [MaxWidth-1:0] DivZeroLo = '1;

  function automatic logic op_is_div(op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic op_is_signed(op_e op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
interface muldiv_ctrl_if
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic             Start;
  op_e              Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             MfReq;
  logic             MtHi;
  logic             MtLo;
  logic             Flush;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             Stall;

  modport master (
    output Start, Op, SrcA, SrcB, MfReq, MtHi, MtLo, Flush,
    input  Hi, Lo, Busy, Done, Stall
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, MfReq, MtHi, MtLo, Flush,
    output Hi, Lo, Busy, Done, Stall
  );

endinterface

// File: rtl/muldiv_dp.sv
// Iterative multiply/divide datapath: operand latches, magnitude prep, one
// shift-add or restoring shift-subtract step per cycle, signed result fixup.
module muldiv_dp
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  op_e              op_i,
  input  logic             latch_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             prep_i,
  input  logic             step_i,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, md_q, md_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic               is_div, is_signed, a_neg, b_neg, quo_bit, div_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   addsub;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    is_div    = op_is_div(op_i);
    is_signed = op_is_signed(op_i);
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    abs_a     = a_neg ? -a_q : a_q;
    abs_b     = b_neg ? -b_q : b_q;

    // One shared adder: remainder trial-subtract for div, partial-product add for mult.
    shifted = {acc_q, mq_q[WIDTH-1]};
    if (is_div) begin
      addsub = {1'b0, shifted} - {2'b00, md_q};
    end else begin
      addsub = {2'b00, acc_q} + {2'b00, {WIDTH{mq_q[0]}} & md_q};
    end
    quo_bit = ~addsub[WIDTH+1];

    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    md_d      = md_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    if (latch_i) begin
      a_d = a_i;
      b_d = b_i;
    end

    if (prep_i) begin
      acc_d     = '0;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      if (is_div) begin
        mq_d = abs_a;
        md_d = abs_b;
      end else begin
        mq_d = abs_b;
        md_d = abs_a;
      end
    end

    if (step_i) begin
      if (is_div) begin
        acc_d = quo_bit ? addsub[WIDTH-1:0] : shifted[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], quo_bit};
      end else begin
        acc_d = addsub[WIDTH:1];
        mq_d  = {addsub[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  // Result is combinational so the controller can capture it on entering DONE.
  always_comb begin
    div_zero = is_div && (b_q == '0);
    prod     = {acc_q, mq_q};
    prod_fix = neg_res_q ? -prod : prod;
    if (div_zero) begin
      res_hi_o = a_q;
      res_lo_o = DivZeroLo[WIDTH-1:0];
    end else if (is_div) begin
      res_hi_o = neg_rem_q ? -acc_q : acc_q;
      res_lo_o = neg_res_q ? -mq_q : mq_q;
    end else begin
      res_hi_o = prod_fix[2*WIDTH-1:WIDTH];
      res_lo_o = prod_fix[WIDTH-1:0];
    end
  end

  assign div_zero_o = div_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      md_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      md_q      <= md_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS HI/LO multiply/divide unit: sequencing FSM, iteration counter,
// HI/LO registers and pipeline stall generation around muldiv_dp.
module muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             dp_latch, dp_prep, dp_step, dp_div_zero;
  logic [WIDTH-1:0] dp_res_hi, dp_res_lo;

  muldiv_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_i       (op_q),
    .latch_i    (dp_latch),
    .a_i        (bus.SrcA),
    .b_i        (bus.SrcB),
    .prep_i     (dp_prep),
    .step_i     (dp_step),
    .div_zero_o (dp_div_zero),
    .res_hi_o   (dp_res_hi),
    .res_lo_o   (dp_res_lo)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dp_latch = 1'b0;
    dp_prep  = 1'b0;
    dp_step  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.Start && !bus.Flush) begin
          state_d  = StPrep;
          op_d     = bus.Op;
          dp_latch = 1'b1;
        end
      end
      StPrep: begin
        if (bus.Flush) begin
          state_d = StIdle;
        end else if (dp_div_zero) begin
          state_d = StDone;
        end else begin
          dp_prep = 1'b1;
          cnt_d   = CNT_W'(WIDTH);
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.Flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          dp_step = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StFixup;
          end
        end
      end
      StFixup: state_d = bus.Flush ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if ((state_q == StIdle) || (state_q == StDone)) begin
      if (bus.MtHi) hi_d = bus.SrcA;
      if (bus.MtLo) lo_d = bus.SrcA;
    end
    // Result write lands on the edge into DONE and overrides any Mt write.
    if (state_d == StDone) begin
      hi_d = dp_res_hi;
      lo_d = dp_res_lo;
    end

    busy_d = state_d inside {StPrep, StRun, StFixup};
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpMult;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Stall = busy_q & (bus.Start | bus.MfReq | bus.MtHi | bus.MtLo);

endmodule
